// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the MIPS pipeline
// Contents: NOP encoding, BEQ opcode (shared with the hazard unit),
// fetch FSM state enum, PC increment helper.
package mips_pkg;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [5:0]  OP_BEQ = 6'b000100;

  typedef enum logic [1:0] {
    START = 2'd0,
    REQ   = 2'd1,
    HELD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  // 32-bit add, wraps naturally at 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with flush > hold > load priority
// Ports: clk, rst (async, active-high); flush, hold, load controls;
// instr_in/pc4_in load data; instr_q/pc4_q/valid_q register contents.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr_q,
  output logic [31:0] pc4_q,
  output logic        valid_q
);

  logic [31:0] instr_d;
  logic [31:0] pc4_d;
  logic        valid_d;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = NOP;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (hold) begin
      instr_d = instr_q;
    end else if (load) begin
      instr_d = instr_in;
      pc4_d   = pc4_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= NOP;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem req/ack FSM, skid buffer, IF/ID
// Ports: clk, rst (async, active-high); holdPC/holdIF_ID stall inputs;
// branch_taken/branch_target redirect; imem_req/imem_addr/imem_ack/imem_rdata
// memory handshake; IF_ID_Instr/IF_ID_PC4/IF_ID_valid to decode.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        holdPC,
  input  logic        holdIF_ID,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  skid_q, skid_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_q, req_d;

  logic         stall;
  logic [31:0]  target;
  logic         ifid_flush, ifid_hold, ifid_load;
  logic [31:0]  ifid_instr;

  assign stall  = holdPC | holdIF_ID;
  assign target = branch_target & ~32'h3;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    skid_d     = skid_q;
    ifid_flush = 1'b0;
    ifid_hold  = 1'b0;
    ifid_load  = 1'b0;
    ifid_instr = skid_q;

    case (state_q)
      START: begin
        state_d = REQ;
        if (branch_taken) begin
          ifid_flush = 1'b1;
          pc_d       = target;
          skid_d     = 32'h0;
        end
      end
      REQ: begin
        if (branch_taken) begin
          ifid_flush = 1'b1;
          pc_d       = target;
          skid_d     = 32'h0;
          // Without the ack the old request is still in flight; DROP waits it out.
          state_d    = imem_ack ? REQ : DROP;
        end else if (imem_ack && !stall) begin
          ifid_load  = 1'b1;
          ifid_instr = imem_rdata;
          pc_d       = pc_plus4(pc_q);
        end else if (imem_ack) begin
          // Stall in the ack cycle: park the word so it is not lost.
          skid_d     = imem_rdata;
          ifid_hold  = 1'b1;
          state_d    = HELD;
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end else begin
          ifid_hold  = 1'b1;
        end
      end
      HELD: begin
        if (branch_taken) begin
          ifid_flush = 1'b1;
          pc_d       = target;
          skid_d     = 32'h0;
          state_d    = REQ;
        end else if (stall) begin
          ifid_hold  = 1'b1;
        end else begin
          ifid_load  = 1'b1;
          ifid_instr = skid_q;
          pc_d       = pc_plus4(pc_q);
          state_d    = REQ;
        end
      end
      DROP: begin
        ifid_flush = 1'b1;
        if (branch_taken) pc_d = target;
        if (imem_ack) state_d = REQ;
      end
      default: state_d = START;
    endcase

    req_d  = (state_d == REQ) || (state_d == DROP);
    // The abandoned request keeps its address on the bus until it is acked.
    addr_d = (state_d == DROP) ? addr_q : pc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= START;
      pc_q    <= RESET_PC;
      skid_q  <= 32'h0;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .flush    (ifid_flush),
    .hold     (ifid_hold),
    .load     (ifid_load),
    .instr_in (ifid_instr),
    .pc4_in   (pc_plus4(pc_q)),
    .instr_q  (IF_ID_Instr),
    .pc4_q    (IF_ID_PC4),
    .valid_q  (IF_ID_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        holdPC = 1'b0;
  logic        holdIF_ID = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PC4;
  logic        IF_ID_valid;

  int checks = 0;
  int failures = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .holdPC        (holdPC),
    .holdIF_ID     (holdIF_ID),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .IF_ID_Instr   (IF_ID_Instr),
    .IF_ID_PC4     (IF_ID_PC4),
    .IF_ID_valid   (IF_ID_valid)
  );

  always #5 clk = ~clk;

  // Memory returns addr ^ 0x1000_0000 as the instruction word.
  task automatic mem(input logic a);
    imem_ack   = a;
    imem_rdata = a ? (imem_addr ^ 32'h1000_0000) : 32'h0;
  endtask

  // Reset, release, and land at the negedge where the first request is up.
  task automatic do_reset();
    rst = 1'b1; holdPC = 0; holdIF_ID = 0; branch_taken = 0; branch_target = 0;
    imem_ack = 0; imem_rdata = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=00000000", imem_addr); end
    checks++; if (IF_ID_Instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=00000000", IF_ID_Instr); end
    checks++; if (IF_ID_PC4 !== 32'h0) begin failures++; $display("FAIL rst_pc4 got=%h exp=00000000", IF_ID_PC4); end
    checks++; if (IF_ID_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", IF_ID_valid); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL first_addr got=%h exp=00000000", imem_addr); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_i [3] = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0008};
    logic [31:0] exp_p [3] = '{32'h4, 32'h8, 32'hC};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      mem(1'b1);
      @(negedge clk);
      checks++; if (IF_ID_Instr !== exp_i[i]) begin failures++; $display("FAIL zw_instr%0d got=%h exp=%h", i, IF_ID_Instr, exp_i[i]); end
      checks++; if (IF_ID_PC4 !== exp_p[i]) begin failures++; $display("FAIL zw_pc4%0d got=%h exp=%h", i, IF_ID_PC4, exp_p[i]); end
      checks++; if (IF_ID_valid !== 1'b1) begin failures++; $display("FAIL zw_valid%0d got=%b exp=1", i, IF_ID_valid); end
    end
    mem(1'b0);
  endtask

  task automatic test_wait2();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      mem(1'b0);
      @(negedge clk);
      checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin failures++; $display("FAIL w2_hold%0d got=%h/%b exp=00000000/1", i, imem_addr, imem_req); end
      checks++; if (IF_ID_valid !== 1'b0) begin failures++; $display("FAIL w2_bubble%0d got=%b exp=0", i, IF_ID_valid); end
    end
    mem(1'b1);
    @(negedge clk);
    checks++; if (IF_ID_Instr !== 32'h1000_0000 || IF_ID_valid !== 1'b1) begin failures++; $display("FAIL w2_load got=%h/%b exp=10000000/1", IF_ID_Instr, IF_ID_valid); end
    checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL w2_next_addr got=%h exp=00000004", imem_addr); end
    mem(1'b0);
    @(negedge clk);
    checks++; if (IF_ID_valid !== 1'b0) begin failures++; $display("FAIL w2_pulse got=%b exp=0", IF_ID_valid); end
  endtask

  task automatic test_stall_ack();
    do_reset();
    mem(1'b1);
    @(negedge clk);
    mem(1'b1); holdIF_ID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem(1'b0);
      checks++; if (IF_ID_Instr !== 32'h1000_0000 || IF_ID_PC4 !== 32'h4) begin failures++; $display("FAIL st_keep%0d got=%h/%h exp=10000000/00000004", i, IF_ID_Instr, IF_ID_PC4); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL st_noreq%0d got=%b exp=0", i, imem_req); end
    end
    holdIF_ID = 1'b0;
    @(negedge clk);
    checks++; if (IF_ID_Instr !== 32'h1000_0004 || IF_ID_PC4 !== 32'h8 || IF_ID_valid !== 1'b1) begin failures++; $display("FAIL st_skid got=%h/%h/%b exp=10000004/00000008/1", IF_ID_Instr, IF_ID_PC4, IF_ID_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL st_resume got=%b/%h exp=1/00000008", imem_req, imem_addr); end
    mem(1'b1);
    @(negedge clk);
    checks++; if (IF_ID_Instr !== 32'h1000_0008 || IF_ID_PC4 !== 32'hC) begin failures++; $display("FAIL st_next got=%h/%h exp=10000008/0000000c", IF_ID_Instr, IF_ID_PC4); end
    mem(1'b0);
  endtask

  task automatic test_branch_stall();
    do_reset();
    mem(1'b1);
    @(negedge clk);
    mem(1'b0); holdPC = 1'b1;
    @(negedge clk);
    checks++; if (IF_ID_Instr !== 32'h1000_0000 || IF_ID_valid !== 1'b1) begin failures++; $display("FAIL bs_hold got=%h/%b exp=10000000/1", IF_ID_Instr, IF_ID_valid); end
    mem(1'b1); branch_taken = 1'b1; branch_target = 32'h0000_0043;
    @(negedge clk);
    branch_taken = 1'b0; holdPC = 1'b0;
    checks++; if (IF_ID_Instr !== 32'h0 || IF_ID_PC4 !== 32'h0 || IF_ID_valid !== 1'b0) begin failures++; $display("FAIL bs_flush got=%h/%h/%b exp=00000000/00000000/0", IF_ID_Instr, IF_ID_PC4, IF_ID_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin failures++; $display("FAIL bs_target got=%b/%h exp=1/00000040", imem_req, imem_addr); end
    mem(1'b1);
    @(negedge clk);
    checks++; if (IF_ID_Instr !== 32'h1000_0040 || IF_ID_PC4 !== 32'h44) begin failures++; $display("FAIL bs_fetch got=%h/%h exp=10000040/00000044", IF_ID_Instr, IF_ID_PC4); end
    mem(1'b0);
  endtask

  task automatic test_branch_outstanding();
    do_reset();
    mem(1'b0); branch_taken = 1'b1; branch_target = 32'h80;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL bo_old1 got=%b/%h exp=1/00000000", imem_req, imem_addr); end
    branch_target = 32'h90;
    @(negedge clk);
    branch_taken = 1'b0;
    checks++; if (imem_addr !== 32'h0 || IF_ID_valid !== 1'b0) begin failures++; $display("FAIL bo_old2 got=%h/%b exp=00000000/0", imem_addr, IF_ID_valid); end
    mem(1'b1);
    @(negedge clk);
    checks++; if (IF_ID_valid !== 1'b0 || IF_ID_Instr !== 32'h0) begin failures++; $display("FAIL bo_drop got=%b/%h exp=0/00000000", IF_ID_valid, IF_ID_Instr); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h90) begin failures++; $display("FAIL bo_target got=%b/%h exp=1/00000090", imem_req, imem_addr); end
    mem(1'b1);
    @(negedge clk);
    checks++; if (IF_ID_Instr !== 32'h1000_0090 || IF_ID_PC4 !== 32'h94 || IF_ID_valid !== 1'b1) begin failures++; $display("FAIL bo_fetch got=%h/%h/%b exp=10000090/00000094/1", IF_ID_Instr, IF_ID_PC4, IF_ID_valid); end
    mem(1'b0);
  endtask

  task automatic test_wrap_reset();
    do_reset();
    mem(1'b1); branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    @(negedge clk);
    branch_taken = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wr_addr got=%h exp=fffffffc", imem_addr); end
    mem(1'b1);
    @(negedge clk);
    checks++; if (IF_ID_Instr !== 32'hEFFF_FFFC || IF_ID_PC4 !== 32'h0 || IF_ID_valid !== 1'b1) begin failures++; $display("FAIL wr_load got=%h/%h/%b exp=effffffc/00000000/1", IF_ID_Instr, IF_ID_PC4, IF_ID_valid); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL wr_wrap got=%h exp=00000000", imem_addr); end
    mem(1'b0); holdIF_ID = 1'b1;
    @(negedge clk);
    checks++; if (IF_ID_valid !== 1'b1 || imem_req !== 1'b1) begin failures++; $display("FAIL wr_wait got=%b/%b exp=1/1", IF_ID_valid, imem_req); end
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin failures++; $display("FAIL wr_rst_mem got=%b/%h exp=0/00000000", imem_req, imem_addr); end
    checks++; if (IF_ID_Instr !== 32'h0 || IF_ID_PC4 !== 32'h0 || IF_ID_valid !== 1'b0) begin failures++; $display("FAIL wr_rst_ifid got=%h/%h/%b exp=00000000/00000000/0", IF_ID_Instr, IF_ID_PC4, IF_ID_valid); end
    holdIF_ID = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL wr_restart got=%b/%h exp=1/00000000", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait2();
    test_stall_ack();
    test_branch_stall();
    test_branch_outstanding();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
